// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants.
// Also used by the transmitter for the default divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int UART_DEFAULT_DIVISOR = 868;
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Reset value is a parameter so idle-high pins come out of reset idle.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, one bit = BAUD_DIVISOR+1 clocks.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVISOR = UART_DEFAULT_DIVISOR
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [9:0] DIV_FULL = 10'(BAUD_DIVISOR);
  localparam logic [9:0] DIV_HALF = 10'(BAUD_DIVISOR / 2);

  state_t state, state_d;

  logic       rx_s;
  logic       rx_q;
  logic       sample;
  logic [9:0] timer, timer_d;
  logic [2:0] cnt, cnt_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic [7:0] data_d;
  logic       valid_d;
  logic       ferr_d;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk100),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk100) begin
    if (!rst_n) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

`ifdef UART_RX_MAJORITY_EN
  logic m2, m1;

  // Two early looks at the line, just before the bit event.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      m2 <= 1'b1;
      m1 <= 1'b1;
    end else if (state != IDLE) begin
      if (timer == 10'd2) m2 <= rx_s;
      if (timer == 10'd1) m1 <= rx_s;
    end
  end

  assign sample = (m2 & m1) | (m2 & rx_s) | (m1 & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      cnt       <= cnt_d;
      shift     <= shift_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    cnt_d   = cnt;
    shift_d = shift;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_q && !rx_s) begin
          timer_d = DIV_HALF;
          state_d = START;
        end
      end
      START: begin
        if (timer != '0) begin
          timer_d = timer - 10'd1;
        end else if (!sample) begin
          timer_d = DIV_FULL;
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (timer != '0) begin
          timer_d = timer - 10'd1;
        end else begin
          shift_d = {sample, shift[UART_DATA_BITS-1:1]};
          timer_d = DIV_FULL;
          cnt_d   = cnt + 3'd1;
          if (cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is not missed.
        if (timer != '0) begin
          timer_d = timer - 10'd1;
        end else begin
          if (sample) begin
            data_d  = shift;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at BAUD_DIVISOR=15 (16 clocks/bit).
// Expected glitch result follows UART_RX_MAJORITY_EN when defined.
module tb_uart_rx;

  logic       clk100 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int nvec = 0;
  int nerr = 0;

  int vcnt;
  int fcnt;
  int bcnt;
  int bad_busy;
  int both;
  int cyc = 0;
  logic [7:0] last;
  logic prev_busy = 1'b0;
  int vcyc[$];
  logic [7:0] vdat[$];

  uart_rx #(
    .BAUD_DIVISOR(15)
  ) dut (
    .clk100   (clk100),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) begin
    cyc++;
    if (valid === 1'b1) begin
      vcnt++;
      last = data;
      vcyc.push_back(cyc);
      vdat.push_back(data);
      if (busy !== 1'b0 || prev_busy !== 1'b1) bad_busy++;
    end
    if (frame_err === 1'b1) fcnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both++;
    if (busy === 1'b1) bcnt++;
    prev_busy = busy;
  end

  task automatic clear();
    vcnt = 0;
    fcnt = 0;
    bcnt = 0;
    bad_busy = 0;
    both = 0;
    last = 8'hxx;
    vcyc.delete();
    vdat.delete();
  endtask

  task automatic tick(input logic v);
    rx = v;
    @(posedge clk100);
    #1;
  endtask

  // goff: clock within each data bit to invert (-1 none)
  // rst_at: clock within frame to pulse reset (-1 none)
  task automatic send(input logic [7:0] b, input logic stopb,
                      input int goff, input int rst_at);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 16; c++) begin
        logic v;
        v = f[k];
        if (k >= 1 && k <= 8 && c == goff) v = ~v;
        rst_n = (16 * k + c == rst_at) ? 1'b0 : 1'b1;
        tick(v);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'b1);
    nvec++;
    if (data !== 8'h00) begin
      nerr++;
      $display("FAIL reset_data: got %h want 00", data);
    end
    nvec++;
    if (valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid: got %b want 0", valid);
    end
    nvec++;
    if (frame_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ferr: got %b want 0", frame_err);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    repeat (5) tick(1'b1);
  endtask

  task automatic test_single();
    clear();
    send(8'hA5, 1'b1, -1, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 1) begin
      nerr++;
      $display("FAIL a5_count: got %0d want 1", vcnt);
    end
    nvec++;
    if (last !== 8'hA5) begin
      nerr++;
      $display("FAIL a5_data: got %h want a5", last);
    end
    nvec++;
    if (fcnt !== 0) begin
      nerr++;
      $display("FAIL a5_ferr: got %0d want 0", fcnt);
    end
    nvec++;
    if (bad_busy !== 0) begin
      nerr++;
      $display("FAIL a5_busy_fall: got %0d want 0", bad_busy);
    end
    nvec++;
    if (data !== 8'hA5) begin
      nerr++;
      $display("FAIL a5_hold: got %h want a5", data);
    end
  endtask

  task automatic test_back_to_back();
    clear();
    send(8'h00, 1'b1, -1, -1);
    send(8'hFF, 1'b1, -1, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 2) begin
      nerr++;
      $display("FAIL b2b_count: got %0d want 2", vcnt);
    end
    nvec++;
    if (vdat.size() != 2) begin
      nerr++;
      $display("FAIL b2b_data: got %0d bytes want 2", vdat.size());
    end else if (vdat[0] !== 8'h00 || vdat[1] !== 8'hFF) begin
      nerr++;
      $display("FAIL b2b_data: got %h %h want 00 ff",
               vdat[0], vdat[1]);
    end
    nvec++;
    if (vcyc.size() != 2) begin
      nerr++;
      $display("FAIL b2b_gap: got %0d pulses want 2", vcyc.size());
    end else if (vcyc[1] - vcyc[0] != 160) begin
      nerr++;
      $display("FAIL b2b_gap: got %0d want 160", vcyc[1] - vcyc[0]);
    end
    nvec++;
    if (fcnt !== 0) begin
      nerr++;
      $display("FAIL b2b_ferr: got %0d want 0", fcnt);
    end
  endtask

  task automatic test_start_glitch();
    clear();
    repeat (4) tick(1'b0);
    repeat (24) tick(1'b1);
    nvec++;
    if (vcnt !== 0 || fcnt !== 0) begin
      nerr++;
      $display("FAIL glitch_strobe: got v=%0d f=%0d want 0 0",
               vcnt, fcnt);
    end
    nvec++;
    if (bcnt !== 8) begin
      nerr++;
      $display("FAIL glitch_busy: got %0d want 8", bcnt);
    end
  endtask

  task automatic test_break();
    clear();
    send(8'h3C, 1'b0, -1, -1);
    nvec++;
    if (fcnt !== 1) begin
      nerr++;
      $display("FAIL brk_ferr: got %0d want 1", fcnt);
    end
    nvec++;
    if (vcnt !== 0) begin
      nerr++;
      $display("FAIL brk_valid: got %0d want 0", vcnt);
    end
    nvec++;
    if (data !== 8'hFF) begin
      nerr++;
      $display("FAIL brk_data: got %h want ff", data);
    end
    nvec++;
    if (both !== 0) begin
      nerr++;
      $display("FAIL brk_both: got %0d want 0", both);
    end
    clear();
    repeat (40 * 16) tick(1'b0);
    nvec++;
    if (bcnt !== 0 || fcnt !== 0 || vcnt !== 0) begin
      nerr++;
      $display("FAIL brk_quiet: got b=%0d f=%0d v=%0d want 0 0 0",
               bcnt, fcnt, vcnt);
    end
    repeat (16) tick(1'b1);
    clear();
    send(8'h55, 1'b1, -1, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 1 || last !== 8'h55) begin
      nerr++;
      $display("FAIL brk_recover: got n=%0d d=%h want 1 55",
               vcnt, last);
    end
  endtask

  task automatic test_reset_abort();
    clear();
    send(8'hF0, 1'b1, -1, 16 * 5 + 8);
    repeat (40) tick(1'b1);
    nvec++;
    if (vcnt !== 0 || fcnt !== 0) begin
      nerr++;
      $display("FAIL abort_strobe: got v=%0d f=%0d want 0 0",
               vcnt, fcnt);
    end
    nvec++;
    if (busy !== 1'b0 || data !== 8'h00) begin
      nerr++;
      $display("FAIL abort_state: got busy=%b d=%h want 0 00",
               busy, data);
    end
    clear();
    send(8'h81, 1'b1, -1, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 1 || last !== 8'h81) begin
      nerr++;
      $display("FAIL abort_next: got n=%0d d=%h want 1 81",
               vcnt, last);
    end
  endtask

  task automatic test_sample_glitch();
    logic [7:0] want;
    clear();
    send(8'h5A, 1'b1, 7, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 1 || last !== 8'h5A) begin
      nerr++;
      $display("FAIL glitch_t1: got n=%0d d=%h want 1 5a",
               vcnt, last);
    end
`ifdef UART_RX_MAJORITY_EN
    want = 8'h5A;
`else
    want = 8'hA5;
`endif
    clear();
    send(8'h5A, 1'b1, 8, -1);
    repeat (8) tick(1'b1);
    nvec++;
    if (vcnt !== 1 || last !== want) begin
      nerr++;
      $display("FAIL glitch_t0: got n=%0d d=%h want 1 %h",
               vcnt, last, want);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk100);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_break();
    test_reset_abort();
    test_sample_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
